// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI4 constants, response type and size helper
package axi_pkg;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;

   typedef logic [1:0] axi_resp_t;

   localparam axi_resp_t RESP_OKAY   = 2'b00;
   localparam axi_resp_t RESP_EXOKAY = 2'b01;
   localparam axi_resp_t RESP_SLVERR = 2'b10;
   localparam axi_resp_t RESP_DECERR = 2'b11;

   // AxSIZE encoding for a bus of the given byte width (log2 of bytes per beat)
   function automatic logic [2:0] size_of(input int unsigned bytes);
      logic [2:0] r_size;
      r_size = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if ((32'd1 << i) == bytes) begin
            r_size = 3'(i);
         end
      end
      return r_size;
   endfunction

endpackage

// File: rtl/axi_burst_master_if.sv
// rtl/axi_burst_master_if.sv - AXI4 AW/W/B/AR/R channel bundle with master/slave views
interface axi_burst_master_if #(
   parameter int ADDR_WIDTH = 28,
   parameter int DATA_WIDTH = 64,
   parameter int ID_WIDTH   = 4,
   parameter int STRB_WIDTH = DATA_WIDTH / 8
);

   logic [ID_WIDTH-1:0]   awid;
   logic [ADDR_WIDTH-1:0] awaddr;
   logic [7:0]            awlen;
   logic [2:0]            awsize;
   logic [1:0]            awburst;
   logic                  awvalid;
   logic                  awready;

   logic [DATA_WIDTH-1:0] wdata;
   logic [STRB_WIDTH-1:0] wstrb;
   logic                  wlast;
   logic                  wvalid;
   logic                  wready;

   logic [ID_WIDTH-1:0]   bid;
   logic [1:0]            bresp;
   logic                  bvalid;
   logic                  bready;

   logic [ID_WIDTH-1:0]   arid;
   logic [ADDR_WIDTH-1:0] araddr;
   logic [7:0]            arlen;
   logic [2:0]            arsize;
   logic [1:0]            arburst;
   logic                  arvalid;
   logic                  arready;

   logic [ID_WIDTH-1:0]   rid;
   logic [DATA_WIDTH-1:0] rdata;
   logic [1:0]            rresp;
   logic                  rlast;
   logic                  rvalid;
   logic                  rready;

   modport master (
      output awid, awaddr, awlen, awsize, awburst, awvalid,
      input  awready,
      output wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready,
      output arid, araddr, arlen, arsize, arburst, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready
   );

   modport slave (
      input  awid, awaddr, awlen, awsize, awburst, awvalid,
      output awready,
      input  wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready,
      input  arid, araddr, arlen, arsize, arburst, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready
   );

endinterface

// File: rtl/axi_burst_master.sv
// rtl/axi_burst_master.sv - single-command AXI4 INCR burst master (write: stream->AW/W/B, read: AR/R->stream)
module axi_burst_master
   import axi_pkg::*;
#(
   parameter int ADDR_WIDTH = 28,
   parameter int DATA_WIDTH = 64,
   parameter int ID_WIDTH   = 4,
   parameter int AXI_ID     = 0,
   parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [7:0]            cmd_len,

   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [STRB_WIDTH-1:0] wr_strb,
   input  logic                  wr_valid,
   output logic                  wr_ready,

   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_last,
   output logic                  rd_valid,
   input  logic                  rd_ready,

   output logic                  done,
   output axi_resp_t             done_resp,
   output logic                  len_err,

   axi_burst_master_if.master    m_axi
);

   typedef enum logic [2:0] {IDLE, AW, W, B, AR, R, DONE} state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [7:0]            r_len;
   logic [7:0]            r_beat;
   axi_resp_t             r_resp;
   logic                  r_len_err;

   logic      w_cmd_fire;
   logic      w_w_fire;
   logic      w_b_fire;
   logic      w_r_fire;
   logic      w_last_beat;
   logic      w_r_len_bad;
   axi_resp_t w_b_resp_max;
   axi_resp_t w_r_resp_max;
   logic      w_unused;

   assign w_cmd_fire  = cmd_valid & cmd_ready;
   assign w_w_fire    = m_axi.wvalid & m_axi.wready;
   assign w_b_fire    = m_axi.bvalid & m_axi.bready;
   assign w_r_fire    = m_axi.rvalid & m_axi.rready;
   assign w_last_beat = (r_beat == r_len);

   // Early rlast, or reaching the expected count without rlast, are both length errors
   assign w_r_len_bad  = m_axi.rlast ? !w_last_beat : w_last_beat;
   assign w_b_resp_max = (m_axi.bresp > r_resp) ? m_axi.bresp : r_resp;
   assign w_r_resp_max = (m_axi.rresp > r_resp) ? m_axi.rresp : r_resp;

   // IDs are not checked with a single transaction outstanding
   assign w_unused = ^{m_axi.bid, m_axi.rid};

   assign m_axi.awid    = ID_WIDTH'(AXI_ID);
   assign m_axi.awaddr  = r_addr;
   assign m_axi.awlen   = r_len;
   assign m_axi.awsize  = size_of(STRB_WIDTH);
   assign m_axi.awburst = AXI_BURST_INCR;
   assign m_axi.arid    = ID_WIDTH'(AXI_ID);
   assign m_axi.araddr  = r_addr;
   assign m_axi.arlen   = r_len;
   assign m_axi.arsize  = size_of(STRB_WIDTH);
   assign m_axi.arburst = AXI_BURST_INCR;
   assign m_axi.wdata   = wr_data;
   assign m_axi.wstrb   = wr_strb;

   assign rd_data   = m_axi.rdata;
   assign rd_last   = m_axi.rlast;
   assign done_resp = done ? r_resp : RESP_OKAY;
   assign len_err   = r_len_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      cmd_ready     = 1'b0;
      wr_ready      = 1'b0;
      rd_valid      = 1'b0;
      done          = 1'b0;
      m_axi.awvalid = 1'b0;
      m_axi.wvalid  = 1'b0;
      m_axi.wlast   = 1'b0;
      m_axi.bready  = 1'b0;
      m_axi.arvalid = 1'b0;
      m_axi.rready  = 1'b0;
      case (r_state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               w_state_nxt = cmd_write ? AW : AR;
            end
         end
         AW: begin
            m_axi.awvalid = 1'b1;
            if (m_axi.awready) begin
               w_state_nxt = W;
            end
         end
         W: begin
            m_axi.wvalid = wr_valid;
            wr_ready     = m_axi.wready;
            m_axi.wlast  = w_last_beat;
            if (wr_valid && m_axi.wready && w_last_beat) begin
               w_state_nxt = B;
            end
         end
         B: begin
            m_axi.bready = 1'b1;
            if (m_axi.bvalid) begin
               w_state_nxt = DONE;
            end
         end
         AR: begin
            m_axi.arvalid = 1'b1;
            if (m_axi.arready) begin
               w_state_nxt = R;
            end
         end
         R: begin
            rd_valid     = m_axi.rvalid;
            m_axi.rready = rd_ready;
            if (m_axi.rvalid && rd_ready && m_axi.rlast) begin
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            done        = 1'b1;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_addr    <= '0;
         r_len     <= '0;
         r_beat    <= '0;
         r_resp    <= RESP_OKAY;
         r_len_err <= 1'b0;
      end else if (w_cmd_fire) begin
         r_addr <= cmd_addr;
         r_len  <= cmd_len;
         r_beat <= '0;
         r_resp <= RESP_OKAY;
      end else if (w_w_fire) begin
         r_beat <= r_beat + 8'd1;
      end else if (w_b_fire) begin
         r_resp <= w_b_resp_max;
      end else if (w_r_fire) begin
         r_beat <= r_beat + 8'd1;
         r_resp <= w_r_resp_max;
         if (w_r_len_bad) begin
            r_len_err <= 1'b1;
         end
      end
   end

endmodule

// File: doc/axi_burst_master.md
Name: axi_burst_master

Overview:
- AXI4 master that turns single-command block transfers into one INCR burst: write (stream in, then AW/W/B) or read (AR/R, then stream out).
- Sits between on-chip engines (DMA, framebuffer fetch) and the AXI memory port of the SDRAM/DDR subsystem.
- One transaction in flight at a time; no outstanding-transaction overlap between read and write.

Parameters:
- ADDR_WIDTH, 28, byte address width.
- DATA_WIDTH, 64, data bus width in bits; a power of two, at least 8.
- ID_WIDTH, 4, AXI ID width.
- AXI_ID, 0, constant ID driven on awid/arid.
- STRB_WIDTH, DATA_WIDTH/8, byte strobe width.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid / cmd_ready  in / out  1 / 1  command handshake.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  ADDR_WIDTH  start byte address, aligned to STRB_WIDTH.
- cmd_len  in  8  beats minus 1 (0..255).
- wr_data / wr_strb  in  DATA_WIDTH / STRB_WIDTH  write stream payload.
- wr_valid / wr_ready  in / out  1 / 1  write stream handshake.
- rd_data  out  DATA_WIDTH  read stream payload.
- rd_last  out  1  marks the final beat.
- rd_valid / rd_ready  out / in  1 / 1  read stream handshake.
- done  out  1  one-cycle pulse when the transaction completes.
- done_resp  out  2  worst response for the transaction; valid while done=1.
- len_err  out  1  sticky; rlast position mismatched the expected beat count.
- m_axi_aw{id,addr,len,size,burst}  out  ID_WIDTH/ADDR_WIDTH/8/3/2; m_axi_awvalid out 1; m_axi_awready in 1.
- m_axi_w{data,strb,last,valid}  out  DATA_WIDTH/STRB_WIDTH/1/1; m_axi_wready in 1.
- m_axi_b{id,resp,valid}  in  ID_WIDTH/2/1; m_axi_bready out 1.
- m_axi_ar{id,addr,len,size,burst,valid}  out  as the AW channel; m_axi_arready in 1.
- m_axi_r{id,data,resp,last,valid}  in  ID_WIDTH/DATA_WIDTH/2/1/1; m_axi_rready out 1.

Behaviour:
- Reset: state IDLE.
  - All valid/ready outputs 0, except cmd_ready = 1 in IDLE.
  - done = 0, done_resp = 0, len_err = 0, beat counter 0, address/len registers 0.
  - Reset mid-burst abandons the transaction immediately; no cleanup beats are issued.
- Constant outputs: awsize = arsize = $clog2(STRB_WIDTH); awburst = arburst = 2'b01 (INCR); awid = arid = AXI_ID.
- Command is accepted on cmd_valid & cmd_ready; cmd_ready = 1 only in IDLE.
  - On accept, register addr and len, clear the resp accumulator and beat counter.
  - Next state: AW if cmd_write = 1, else AR.
- AW: awvalid = 1; addr/len held stable until awready. On handshake go to W.
- W: combinational pass-through.
  - m_axi_wvalid = wr_valid; wr_ready = m_axi_wready; wdata/wstrb = wr_data/wr_strb.
  - wlast = (beat == len). Counter increments on each W handshake.
  - On the handshake with wlast go to B. Outside W, wr_ready = 0.
- B: bready = 1. On bvalid, capture bresp into the resp accumulator and go to DONE.
- AR: arvalid = 1 until arready, then go to R.
- R: combinational pass-through.
  - rd_valid = rvalid; m_axi_rready = rd_ready; rd_data = rdata; rd_last = rlast.
  - On each handshake: resp accumulator = max(accumulator, rresp); beat counter increments.
  - rlast with beat != len sets len_err; go to DONE.
  - Beat == len without rlast sets len_err; keep accepting beats until rlast.
- DONE: one cycle. done = 1, done_resp = accumulator, then return to IDLE. Next cmd is accepted no earlier than the cycle after DONE.
- Boundary conditions:
  - cmd_len = 0 gives a single beat with wlast/rd_last asserted on beat 0.
  - 4 KiB crossing is the requester's responsibility and is not checked or split.
  - Unaligned cmd_addr is passed through unchanged.
- IDs are not checked; one transaction outstanding.
- Any stall (awready, wready, wr_valid, rvalid, rd_ready low) holds state with no counter change and no timeout.

Decomposition:
- Package axi_pkg holds:
  - AXI_BURST_INCR = 2'b01.
  - RESP_OKAY/EXOKAY/SLVERR/DECERR.
  - typedef axi_resp_t.
  - Function size_of(bytes) returning awsize.
- State enum {IDLE, AW, W, B, AR, R, DONE} is local to the module.
- No sub-module; the FSM and the 8-bit beat counter stay in one file.

Test Plan:
- Write, addr 0x100, len 3, 4 beats 0x11..0x44 with strb 0xFF → single AW with awlen = 3. wlast only on the 4th beat. done pulses with done_resp = 0. A read-back of 0x100..0x118 returns 0x11..0x44.
- Read, len 0, slave rresp = 2'b10 → rd_last on the only beat; done_resp = 2'b10, len_err = 0.
- Read, len 7, with rd_ready toggling every other cycle and arready delayed 5 cycles → 8 beats delivered in order. rready mirrors rd_ready. The counter freezes while stalled.
- Write, len 2, with wr_valid gapped → wvalid follows wr_valid; no beats duplicated or lost; exactly one bready handshake.
- Slave asserts rlast on beat 2 of len 4 → len_err = 1 and done asserts after that beat. The next command is accepted.
- Assert rst in W after beat 1 → all valids and done go to 0 asynchronously. After release, cmd_ready = 1 and a fresh write completes normally.
